// File: rtl/nonce_sweeper.sv
// Nonce sweep controller: latches a job, feeds nonces to the SHA-256d core one at a
// time and stops on the first hash at or below target, or when the nonce range runs out.
module nonce_sweeper #(
  parameter logic [31:0] NONCE_START = 32'h0000_0000,
  parameter logic [31:0] NONCE_END   = 32'hFFFF_FFFF,
  parameter logic [31:0] NONCE_STEP  = 32'd1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         stop,
  input  logic [255:0] midstate,
  input  logic [95:0]  header_leftovers,
  input  logic [255:0] target,
  output logic         core_valid,
  output logic [255:0] core_midstate,
  output logic [127:0] core_block,
  input  logic         core_done,
  input  logic [255:0] core_hash,
  output logic [2:0]   state,
  output logic [31:0]  nonce,
  output logic [31:0]  hash_count
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD      = 3'd1,
    S_HASH      = 3'd2,
    S_CHECK     = 3'd3,
    S_FOUND     = 3'd4,
    S_EXHAUSTED = 3'd5
  } state_e;

  state_e         state_q, state_d;
  logic [31:0]    nonce_q, nonce_d;
  logic [31:0]    count_q, count_d;
  logic [255:0]   mid_q, mid_d;
  logic [95:0]    left_q, left_d;
  logic [255:0]   tgt_q, tgt_d;
  logic [255:0]   hash_q, hash_d;
  logic [32:0]    nonce_sum;
  logic           hit;
  logic           exhausted;

  // The 33-bit sum catches both overshooting NONCE_END and wrapping past 2^32.
  assign nonce_sum = {1'b0, nonce_q} + {1'b0, NONCE_STEP};
  assign hit       = (hash_q <= tgt_q);
  assign exhausted = (nonce_sum > {1'b0, NONCE_END});

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (stop) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_FOUND, S_EXHAUSTED: if (start) state_d = S_LOAD;
        S_LOAD:  state_d = S_HASH;
        S_HASH:  if (core_done) state_d = S_CHECK;
        S_CHECK: begin
          if (hit)            state_d = S_FOUND;
          else if (exhausted) state_d = S_EXHAUSTED;
          else                state_d = S_LOAD;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Job shadow registers only move on an accepted start, so host writes mid-sweep are invisible.
  always_comb begin
    nonce_d = nonce_q;
    count_d = count_q;
    mid_d   = mid_q;
    left_d  = left_q;
    tgt_d   = tgt_q;
    hash_d  = hash_q;
    if (!stop) begin
      case (state_q)
        S_IDLE, S_FOUND, S_EXHAUSTED: begin
          if (start) begin
            mid_d   = midstate;
            left_d  = header_leftovers;
            tgt_d   = target;
            nonce_d = NONCE_START;
            count_d = 32'd0;
          end
        end
        S_HASH: begin
          if (core_done) begin
            hash_d = core_hash;
            if (count_q != 32'hFFFF_FFFF) count_d = count_q + 32'd1;
          end
        end
        S_CHECK: begin
          if (!hit && !exhausted) nonce_d = nonce_sum[31:0];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      nonce_q <= NONCE_START;
      count_q <= 32'd0;
      mid_q   <= '0;
      left_q  <= '0;
      tgt_q   <= '0;
      hash_q  <= '0;
    end else begin
      nonce_q <= nonce_d;
      count_q <= count_d;
      mid_q   <= mid_d;
      left_q  <= left_d;
      tgt_q   <= tgt_d;
      hash_q  <= hash_d;
    end
  end

  always_comb begin
    core_valid    = (state_q == S_LOAD);
    core_midstate = mid_q;
    core_block    = {left_q, nonce_q};
    state         = state_q;
    nonce         = nonce_q;
    hash_count    = count_q;
  end

endmodule
